shift_sequencer: RTL and testbench

- Control stage directly upstream of the 16-bit shifter datapath, which is built from four cascaded 4-bit universal shift-register slices with modes hold/right/left/load.
- Accepts a shift command and drives the slices' mode selects, parallel load bus and end serial inputs for AMT cycles.
- Reads back the slice outputs for rotate/arithmetic fill and carry capture.
- Reports BUSY/DONE/CARRY to the execute stage.

---
 rtl/shift_sequencer_pkg.sv | 45 ++++
 rtl/shift_sequencer_if.sv | 30 +++
 rtl/shift_sequencer.sv | 103 ++++++++++
 tb/tb_shift_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the shifter control stage: op codes, slice modes, FSM states.
// SHIFT_RCX_EN adds rotate-through-carry ops RCL/RCR.
package shift_sequencer_pkg;

  localparam logic [2:0] OP_SHL = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_ROL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;
  localparam logic [2:0] OP_RCL = 3'b101;
  localparam logic [2:0] OP_RCR = 3'b110;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_RCX_EN
    return (op != 3'b111);
`else
    return (op <= OP_ASR);
`endif
  endfunction

  // Left-moving ops; everything else legal shifts right.
  function automatic logic op_is_left(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_ROL) || (op == OP_RCL);
  endfunction

  function automatic logic op_is_rcx(input logic [2:0] op);
`ifdef SHIFT_RCX_EN
    return (op == OP_RCL) || (op == OP_RCR);
`else
    return (op == 3'b111) && (op != 3'b111);
`endif
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/slice bus between the execute stage, the shift sequencer and the shifter slices.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4
);
  logic             START;
  logic [2:0]       OP;
  logic [AW-1:0]    AMT;
  logic [WIDTH-1:0] DIN;
  logic [WIDTH-1:0] Q;
  logic             S1;
  logic             S0;
  logic [WIDTH-1:0] PIN;
  logic             LSB_IN;
  logic             MSB_IN;
  logic             BUSY;
  logic             DONE;
  logic             CARRY;
  logic             ILLEGAL;

  modport master (
    output START, OP, AMT, DIN, Q,
    input  S1, S0, PIN, LSB_IN, MSB_IN, BUSY, DONE, CARRY, ILLEGAL
  );

  modport slave (
    input  START, OP, AMT, DIN, Q,
    output S1, S0, PIN, LSB_IN, MSB_IN, BUSY, DONE, CARRY, ILLEGAL
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequences four cascaded 4-bit universal shift slices through load + AMT shift steps.
// Define SHIFT_RCX_EN to enable RCL/RCR (rotate through carry).
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4
) (
  input logic             CLOCK,
  input logic             RESET,
  shift_sequencer_if.slave bus
);

  state_t         state;
  state_t         state_nxt;
  logic [2:0]     op_q;
  logic [AW-1:0]  cnt;
  logic           carry_q;
  logic           illegal_q;
  logic [1:0]     mode;
  logic [WIDTH-1:0] pin;
  logic           lsb_in;
  logic           msb_in;
  logic           is_left;

  assign is_left = op_is_left(op_q);

  // State, latched command, step counter and carry capture.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            op_q      <= bus.OP;
            cnt       <= bus.AMT;
            illegal_q <= ~op_legal(bus.OP);
          end
        end
        ST_LOAD: begin
          if (!op_is_rcx(op_q)) carry_q <= 1'b0;
        end
        ST_SHIFT: begin
          cnt     <= cnt - AW'(1);
          carry_q <= is_left ? bus.Q[WIDTH-1] : bus.Q[0];
        end
        default: ;
      endcase
    end
  end

  // Next state and slice control decode.
  always_comb begin
    state_nxt = state;
    mode      = MODE_HOLD;
    pin       = '0;
    lsb_in    = 1'b0;
    msb_in    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.START) state_nxt = op_legal(bus.OP) ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: begin
        mode      = MODE_LOAD;
        pin       = bus.DIN;
        state_nxt = (cnt != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        mode = is_left ? MODE_LEFT : MODE_RIGHT;
        case (op_q)
          OP_ROL: lsb_in = bus.Q[WIDTH-1];
          OP_ROR: msb_in = bus.Q[0];
          OP_ASR: msb_in = bus.Q[WIDTH-1];
`ifdef SHIFT_RCX_EN
          OP_RCL: lsb_in = carry_q;
          OP_RCR: msb_in = carry_q;
`endif
          default: ;
        endcase
        if (cnt == AW'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.S1      = mode[1];
  assign bus.S0      = mode[0];
  assign bus.PIN     = pin;
  assign bus.LSB_IN  = lsb_in;
  assign bus.MSB_IN  = msb_in;
  assign bus.BUSY    = (state == ST_LOAD) || (state == ST_SHIFT);
  assign bus.DONE    = (state == ST_DONE);
  assign bus.CARRY   = carry_q;
  assign bus.ILLEGAL = (state == ST_DONE) && illegal_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer driving a behavioural 16-bit universal shift register.
module tb_shift_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 4;

  logic CLOCK = 1'b0;
  logic RESET;

  always #5 CLOCK = ~CLOCK;

  shift_sequencer_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .AW(AW)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Shifter datapath: hold / right / left / load on the common selects.
  logic [15:0] slices = 16'h0000;
  always @(posedge CLOCK) begin
    case ({bus.S1, bus.S0})
      2'b11:   slices <= bus.PIN;
      2'b10:   slices <= {slices[14:0], bus.LSB_IN};
      2'b01:   slices <= {bus.MSB_IN, slices[15:1]};
      default: ;
    endcase
  end
  assign bus.Q = slices;

  typedef struct {
    logic [15:0] q;
    logic        carry;
    logic        illegal;
    int          amt;
    int          start_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_n = 0;
  int          sel_n = 0;
  logic [15:0] ref_q = 16'h0000;
  logic        ref_c = 1'b0;

  always @(posedge CLOCK) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result of a whole command, straight from the op definitions.
  task automatic ref_model(input logic [2:0] op, input logic [15:0] din, input int amt,
                           input logic [15:0] qprev, input logic cin,
                           output logic [15:0] q, output logic c, output logic ill);
    logic [16:0] r;
    logic        legal;
    legal = (op <= 3'd4);
`ifdef SHIFT_RCX_EN
    legal = (op <= 3'd6);
`endif
    ill = ~legal;
    q   = qprev;
    c   = cin;
    if (legal) begin
      case (op)
        3'd0: begin q = din << amt; c = (amt == 0) ? 1'b0 : din[16-amt]; end
        3'd1: begin q = din >> amt; c = (amt == 0) ? 1'b0 : din[amt-1]; end
        3'd2: begin
          q = (amt == 0) ? din : ((din << amt) | (din >> (16 - amt)));
          c = (amt == 0) ? 1'b0 : q[0];
        end
        3'd3: begin
          q = (amt == 0) ? din : ((din >> amt) | (din << (16 - amt)));
          c = (amt == 0) ? 1'b0 : q[15];
        end
        3'd4: begin q = 16'($signed(din) >>> amt); c = (amt == 0) ? 1'b0 : din[amt-1]; end
        default: begin
          r = {cin, din};
          for (int i = 0; i < amt; i++)
            r = (op == 3'd5) ? {r[15:0], r[16]} : {r[0], r[16:1]};
          q = r[15:0];
          c = r[16];
        end
      endcase
    end
  endtask

  // Monitor: pops one expectation per DONE pulse.
  always @(negedge CLOCK) begin
    exp_t e;
    if (RESET) begin
      busy_n = 0;
      sel_n  = 0;
    end else begin
      if (bus.BUSY) busy_n++;
      if (bus.S1 || bus.S0) sel_n++;
      if (bus.DONE) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("q", int'(bus.Q), int'(e.q));
          check("carry", int'(bus.CARRY), int'(e.carry));
          check("illegal", int'(bus.ILLEGAL), int'(e.illegal));
          check("done_latency", cyc - e.start_cyc, e.illegal ? 1 : e.amt + 2);
          check("busy_cycles", busy_n, e.illegal ? 0 : e.amt + 1);
          check("active_select_cycles", sel_n, e.illegal ? 0 : e.amt + 1);
        end
        busy_n = 0;
        sel_n  = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] din, input int amt,
                       input bit ghost_busy, input bit ghost_done);
    exp_t e;
    logic ill;
    bit   seen;
    ref_model(op, din, amt, ref_q, ref_c, e.q, e.carry, ill);
    e.illegal   = ill;
    e.amt       = amt;
    e.start_cyc = cyc;
    ref_q       = e.q;
    ref_c       = e.carry;
    sb.push_back(e);
    bus.START = 1'b1;
    bus.OP    = op;
    bus.AMT   = AW'(amt);
    bus.DIN   = din;
    @(posedge CLOCK) #1;
    bus.START = 1'b0;
    if (ghost_busy && !ill) begin
      bus.START = 1'b1;
      bus.OP    = 3'($urandom_range(0, 4));
      bus.AMT   = AW'($urandom_range(1, 15));
      @(posedge CLOCK) #1;
      bus.START = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DONE) begin
        seen = 1'b1;
        break;
      end
      @(posedge CLOCK) #1;
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
    if (ghost_done) bus.START = 1'b1;
    @(posedge CLOCK) #1;
    bus.START = 1'b0;
  endtask

  initial begin
    logic       dummy_c;
    logic       dummy_i;
    logic [2:0] op;
    RESET     = 1'b1;
    bus.START = 1'b0;
    bus.OP    = 3'd0;
    bus.AMT   = '0;
    bus.DIN   = 16'h0000;
    #1;
    check("rst_sel", int'({bus.S1, bus.S0}), 0);
    check("rst_busy_done", int'({bus.BUSY, bus.DONE, bus.ILLEGAL}), 0);
    check("rst_carry", int'(bus.CARRY), 0);
    @(posedge CLOCK) #1;
    @(posedge CLOCK) #1;
    RESET = 1'b0;

    issue(3'd0, 16'h8001, 1, 1'b0, 1'b0);
    issue(3'd3, 16'h0001, 4, 1'b0, 1'b1);
    issue(3'd4, 16'h8000, 3, 1'b0, 1'b0);
    issue(3'd1, 16'hABCD, 0, 1'b1, 1'b1);
    issue(3'd7, 16'h1234, 5, 1'b0, 1'b0);

    // Reset landing in the 2nd shift cycle of ROL by 8: exactly one step has happened.
    bus.START = 1'b1;
    bus.OP    = 3'd2;
    bus.AMT   = AW'(8);
    bus.DIN   = 16'hC35A;
    @(posedge CLOCK) #1;
    bus.START = 1'b0;
    @(posedge CLOCK) #1;
    @(posedge CLOCK) #1;
    RESET = 1'b1;
    #1;
    check("midrst_sel", int'({bus.S1, bus.S0}), 0);
    check("midrst_pin", int'(bus.PIN), 0);
    check("midrst_fill", int'({bus.LSB_IN, bus.MSB_IN}), 0);
    check("midrst_flags", int'({bus.BUSY, bus.DONE, bus.ILLEGAL, bus.CARRY}), 0);
    ref_model(3'd2, 16'hC35A, 1, ref_q, 1'b0, ref_q, dummy_c, dummy_i);
    ref_c = 1'b0;
    @(posedge CLOCK) #1;
    check("midrst_slices_held", int'(slices), int'(ref_q));
    RESET = 1'b0;
    @(posedge CLOCK) #1;
    issue(3'd0, 16'h0003, 2, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      issue(op, 16'($urandom), $urandom_range(0, 15),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge CLOCK);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
